prog_loader_uart: RTL
=====================

Name: prog_loader_uart

Overview:
- Serial program loader sitting directly upstream of the 8-bit accumulator CPU core.
- Receives a framed program image over a UART pin and writes it byte-by-byte into the CPU's 32x8 instruction memory via the write-enable/address/data path.
- Releases the CPU (cpu_run) only after a complete, checksum-verified image.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); legal range 4..65535.
- MEM_DEPTH, 32, max program bytes; address width is clog2(MEM_DEPTH) = 5.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  UART receive line, idle high, asynchronous to clk.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  5  write address.
- mem_data  output  8  write data.
- cpu_run  output  1  high once a valid image is loaded; gates CPU execution.
- busy  output  1  high while a frame is in progress (after header, before DONE/ERROR).
- err  output  1  sticky error flag.
- err_code  output  2  00 none, 01 bad length, 10 checksum mismatch, 11 framing/parity error.

Behaviour:
- One clock domain. rst is synchronous, active-high.
- Reset values: all outputs 0; both FSMs in their idle states; counters 0.
- rx passes through a 2-flop synchroniser before any use (2 cycles of added latency).
- Bit receiver FSM: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: on synchronised rx == 0, go to R_START.
  - R_START: wait CLKS_PER_BIT/2 cycles, then resample. If rx is high, treat as a glitch and return to R_IDLE with no byte and no error. If low, go to R_DATA.
  - R_DATA: sample 8 bits LSB-first, one every CLKS_PER_BIT cycles.
  - R_STOP: sample the stop bit one bit-time later. If the stop bit is 0, raise a framing error.
  - byte_valid pulses one cycle after a good stop sample. The receiver returns to R_IDLE immediately, so back-to-back bytes are accepted.
- Frame FSM: F_HDR, F_LEN, F_DATA, F_SUM, F_DONE, F_ERR.
  - F_HDR: a byte equal to HDR_BYTE goes to F_LEN; any other byte is ignored.
  - F_LEN: length N, legal range 1..MEM_DEPTH. N = 0 or N > MEM_DEPTH goes to F_ERR with code 01. A legal N clears addr to 0 and the running checksum to 0, then goes to F_DATA.
  - F_DATA: each byte drives mem_we = 1 for exactly one cycle (the cycle after byte_valid), with mem_addr = current addr and mem_data = byte. Then addr increments and checksum ^= byte. After the Nth byte, go to F_SUM.
  - F_SUM: a byte equal to the running XOR checksum goes to F_DONE. Any other value goes to F_ERR with code 10.
  - F_DONE: cpu_run = 1, busy = 0.
  - F_ERR: err = 1, cpu_run = 0, busy = 0.
- busy is 1 in F_LEN, F_DATA and F_SUM.
- A framing error in any state except F_HDR goes to F_ERR with code 11. In F_HDR a bad frame is dropped silently.
- Restart: in F_DONE or F_ERR, a HDR_BYTE byte clears err, err_code and cpu_run in the same cycle and goes to F_LEN. Non-header bytes in those states are ignored.
- A HDR_BYTE value received inside F_DATA is data, not a restart.
- cpu_run drops on the restart cycle. The CPU core must be held in reset while cpu_run = 0, so a partially overwritten image never executes.
- addr never wraps: N is bounded by MEM_DEPTH, so the max addr written is MEM_DEPTH-1.
- rst asserted mid-frame: abort immediately. No further mem_we, all outputs 0, and the next byte is treated as a header candidate. Already-written memory is not cleared.
- mem_we, mem_addr and mem_data are registered. mem_addr and mem_data hold their last values when mem_we = 0.

Optional Feature:
- Macro: LOADER_PARITY_EN.
- Defined: frames are 8E1. An even-parity bit is sampled after bit 7 and before the stop bit. A parity mismatch is handled exactly like a framing error (code 11 outside F_HDR, silent drop in F_HDR).
- Undefined: frames are 8N1 and no parity logic is present.

Test Plan:
- Nominal load: send A5, 03, 01, 05, 02, checksum 06 -> mem_we pulses 3 times, at addrs 0/1/2 with data 01/05/02; then cpu_run = 1, err = 0, busy = 0.
- Bad checksum: send A5, 02, 07, 08, then 00 (expected 0F) -> 2 writes occur; err = 1, err_code = 10, cpu_run = 0.
- Bad length: send A5, 21 (33) -> no mem_we; err = 1, err_code = 01. Then send A5, 01, 0A, 0A -> err clears, one write of 0A at addr 0, cpu_run = 1.
- Glitch and framing: a 0-pulse of CLKS_PER_BIT/4 cycles on idle rx -> no byte, no error. A byte with stop bit 0 during F_DATA -> err_code = 11.
- Full depth and back-to-back: A5, 20, then bytes 00..1F with no idle gaps, then checksum 00 -> 32 writes at addrs 0..31 with no missed bytes; cpu_run = 1.
- Reset mid-frame: assert rst for 1 cycle after the 2nd data byte of a 5-byte frame -> outputs 0, no further mem_we. A fresh valid frame then loads correctly.

Source files
------------

// File: rtl/prog_loader_uart.sv
// prog_loader_uart: UART program loader for the 8-bit accumulator CPU.
// It receives a framed image (HDR, LEN, N data bytes, XOR checksum) and
// writes the data bytes into the 32x8 instruction memory. cpu_run is raised
// only after the checksum matches.
// Optional build macro: LOADER_PARITY_EN selects 8E1 frames (even parity).
// Without it, frames are 8N1.
module prog_loader_uart #(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         MEM_DEPTH    = 32,
    parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [7:0]                   mem_data,
    output logic                         cpu_run,
    output logic                         busy,
    output logic                         err,
    output logic [1:0]                   err_code
);
    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA,
`ifdef LOADER_PARITY_EN
        R_PAR,
`endif
        R_STOP
    } rstate_t;

    typedef enum logic [2:0] {F_HDR, F_LEN, F_DATA, F_SUM, F_DONE, F_ERR} fstate_t;

    rstate_t        r_state, r_next;
    fstate_t        f_state, f_next;
    logic           rx_meta, rx_s;
    logic [15:0]    bit_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg, rx_byte, csum;
    logic           par_ok, rx_done, rx_bad, byte_valid, frame_err;
    logic           tick_half, tick_full, len_bad, err_set;
    logic [1:0]     err_val;
    logic [AW-1:0]  addr;
    logic [AW:0]    left;

    assign tick_half = (bit_cnt == 16'(HALF - 1));
    assign tick_full = (bit_cnt == 16'(CLKS_PER_BIT - 1));
    assign len_bad   = (rx_byte == 8'd0) || (int'(rx_byte) > MEM_DEPTH);

`ifdef LOADER_PARITY_EN
    logic par_bit;
    // Even parity: the data bits and the parity bit XOR to zero.
    assign par_ok = ~^{shreg, par_bit};
    // Capture the parity bit in the middle of its bit time.
    always_ff @(posedge clk) begin
        if (rst)                             par_bit <= 1'b0;
        else if (r_state == R_PAR && tick_full) par_bit <= rx_s;
    end
`else
    assign par_ok = 1'b1;
`endif

    // Two-flop synchroniser. Reset loads the idle-high level so no false start is seen.
    always_ff @(posedge clk) begin
        if (rst) {rx_s, rx_meta} <= 2'b11;
        else     {rx_s, rx_meta} <= {rx_meta, rx};
    end

    // Bit receiver state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Bit receiver next state. Sample decisions are made mid-bit.
    always_comb begin
        r_next  = r_state;
        rx_done = 1'b0;
        rx_bad  = 1'b0;
        case (r_state)
            R_IDLE:  if (!rx_s) r_next = R_START;
            R_START: if (tick_half) r_next = rx_s ? R_IDLE : R_DATA;
`ifdef LOADER_PARITY_EN
            R_DATA:  if (tick_full && bit_idx == 3'd7) r_next = R_PAR;
            R_PAR:   if (tick_full) r_next = R_STOP;
`else
            R_DATA:  if (tick_full && bit_idx == 3'd7) r_next = R_STOP;
`endif
            R_STOP: begin
                if (tick_full) begin
                    r_next  = R_IDLE;
                    rx_done = rx_s && par_ok;
                    rx_bad  = !(rx_s && par_ok);
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Bit timer, shift register, and the registered byte/error strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= rx_done;
            frame_err  <= rx_bad;
            if (rx_done) rx_byte <= shreg;
            if (r_state == R_IDLE || r_next != r_state || tick_full) bit_cnt <= '0;
            else                                                     bit_cnt <= bit_cnt + 16'd1;
            if (r_state == R_START) bit_idx <= '0;
            if (r_state == R_DATA && tick_full) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) f_state <= F_HDR;
        else     f_state <= f_next;
    end

    // Frame next state. A framing error outranks byte handling, except in F_HDR.
    always_comb begin
        f_next  = f_state;
        err_set = 1'b0;
        err_val = 2'b00;
        if (frame_err) begin
            if (f_state != F_HDR) begin
                f_next  = F_ERR;
                err_set = 1'b1;
                err_val = 2'b11;
            end
        end else if (byte_valid) begin
            case (f_state)
                F_HDR, F_DONE, F_ERR: if (rx_byte == HDR_BYTE) f_next = F_LEN;
                F_LEN: begin
                    if (len_bad) begin
                        f_next  = F_ERR;
                        err_set = 1'b1;
                        err_val = 2'b01;
                    end else begin
                        f_next = F_DATA;
                    end
                end
                F_DATA: if (left == (AW+1)'(1)) f_next = F_SUM;
                F_SUM: begin
                    if (rx_byte == csum) begin
                        f_next = F_DONE;
                    end else begin
                        f_next  = F_ERR;
                        err_set = 1'b1;
                        err_val = 2'b10;
                    end
                end
                default: f_next = F_HDR;
            endcase
        end
    end

    // Frame datapath and registered outputs. Status flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            left     <= '0;
            csum     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            cpu_run  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            mem_we  <= 1'b0;
            cpu_run <= (f_next == F_DONE);
            err     <= (f_next == F_ERR);
            busy    <= (f_next == F_LEN) || (f_next == F_DATA) || (f_next == F_SUM);
            if (err_set)               err_code <= err_val;
            else if (f_next == F_LEN)  err_code <= 2'b00;
            if (byte_valid && !frame_err) begin
                if (f_state == F_LEN) begin
                    addr <= '0;
                    csum <= '0;
                    left <= rx_byte[AW:0];
                end else if (f_state == F_DATA) begin
                    mem_we   <= 1'b1;
                    mem_addr <= addr;
                    mem_data <= rx_byte;
                    csum     <= csum ^ rx_byte;
                    left     <= left - (AW+1)'(1);
                    // Hold addr on the last byte so it never wraps past MEM_DEPTH-1.
                    if (left != (AW+1)'(1)) addr <= addr + AW'(1);
                end
            end
        end
    end
endmodule
